button_filter: RTL and testbench
================================

BUTTON_FILTER -- requirements
Module: button_filter

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of independent button channels, at least 1.
REQ-002 SHALL have parameter TICK_DIV, default 12000: clk cycles per sample tick, at least 2.
REQ-003 SHALL have parameter STABLE_CNT, default 4: consecutive differing ticks needed to accept a level change, at least 1.
REQ-004 SHALL have parameter HOLD_TICKS, default 500: ticks from accepted press to first repeat, at least 1.
REQ-005 SHALL have parameter REPEAT_TICKS, default 100: ticks between repeats, at least 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port i_btn, input, N_BTN bits: raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL have port o_state, output, N_BTN bits: debounced level per channel.
REQ-010 SHALL have port o_press, output, N_BTN bits: one-cycle pulse per accepted press, and per repeat when repeat is compiled in.
REQ-011 SHALL have port o_release, output, N_BTN bits: one-cycle pulse per accepted release.
REQ-012 SHALL have port o_tick, output, 1 bit: registered copy of the internal sample tick.

Function
REQ-013 SHALL pass each i_btn bit through a 2-flop synchronizer; only the synchronized value feeds the filter.
REQ-014 SHALL run one shared prescaler counting 0..TICK_DIV-1 and wrapping; the tick is high on the cycle the count equals TICK_DIV-1, once per TICK_DIV cycles.
REQ-015 SHALL keep a per-channel counter of width $clog2(STABLE_CNT+1), updated only on tick cycles.
REQ-016 SHALL clear the counter when a channel's synchronized value equals its o_state, and increment it when they differ.
REQ-017 SHALL, on a tick where the counter would reach STABLE_CNT, invert o_state, clear the counter, and pulse o_press (0->1) or o_release (1->0) for exactly the next cycle.
REQ-018 SHALL discard any glitch lasting fewer than STABLE_CNT consecutive ticks: o_state unchanged, no pulse.
REQ-019 SHALL give a latency from a clean input edge to o_state change of 2 sync cycles plus STABLE_CNT-1 to STABLE_CNT full tick periods.
REQ-020 SHALL keep channels fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-021 SHALL keep o_press and o_release mutually exclusive per channel and never high on two consecutive cycles.

Reset
REQ-022 SHALL, while rst is high, clear immediately (not waiting for clk) the prescaler, synchronizers, filter counters, hold and repeat counters, o_state, o_press, o_release and o_tick.
REQ-023 SHALL, when rst asserts mid-filter or mid-pulse, abort that activity with no pulse on deassertion.
REQ-024 SHALL, when a button is held through reset release, report it as a fresh press after STABLE_CNT ticks.

Configuration
REQ-025 SHALL compile auto-repeat in only when macro BUTTON_FILTER_REPEAT_EN is defined.
REQ-026 SHALL, with BUTTON_FILTER_REPEAT_EN defined, keep a per-channel hold counter, saturating and of width $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1), that clears on the accepted press and counts ticks while o_state=1.
REQ-027 SHALL, with the macro defined, emit an extra one-cycle o_press pulse when the counter reaches HOLD_TICKS, then every REPEAT_TICKS ticks while held.
REQ-028 SHALL, with the macro defined, stop repeats and clear the hold counter on release.
REQ-029 SHALL, without BUTTON_FILTER_REPEAT_EN, contain no hold or repeat logic, give exactly one o_press per accepted press, and accept but ignore HOLD_TICKS and REPEAT_TICKS.

Verification
REQ-030 SHALL be verified with TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=8 and REPEAT_TICKS=2.
REQ-031 SHALL verify clean press: i_btn[0] 0->1, held -> o_state[0]=1 within 2+12 cycles, one o_press[0] pulse, o_release quiet.
REQ-032 SHALL verify glitch: i_btn[1] high for 8 cycles (2 ticks), then low -> o_state[1] stays 0, no pulses.
REQ-033 SHALL verify simultaneous events: bits 0 and 3 raised on the same cycle -> o_press=4'b1001 in a single cycle.
REQ-034 SHALL verify reset mid-filter: rst for 1 cycle after 2 differing ticks with button held -> outputs 0 at once, press re-accepted 3 ticks after release of rst.
REQ-035 SHALL verify repeat (macro defined): hold 20 ticks -> o_press at acceptance, then at ticks 8, 10, 12, ... after it; no repeats after release; macro undefined -> single pulse only.
REQ-036 SHALL verify release: button dropped after acceptance -> one o_release pulse 3 ticks later, o_state=0.

Source files
------------

// File: rtl/button_filter.sv
`default_nettype none
// ============================================================================
// Module      : button_filter
// Description : Multi-channel push-button conditioner. Each raw input is
//               brought into the clk domain by a 2-flop synchronizer, then
//               debounced by a per-channel counter that advances only on a
//               shared prescaler tick. Accepted edges produce one-cycle
//               press/release pulses.
//               Optional auto-repeat is compiled in by defining the macro
//               BUTTON_FILTER_REPEAT_EN; without it HOLD_TICKS and
//               REPEAT_TICKS are accepted but have no effect.
// Revision    : 1.0 - initial release
// ============================================================================
module button_filter #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 12000,
  parameter int STABLE_CNT   = 4,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_state,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic             o_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CNT - 1);

`ifdef BUTTON_FILTER_REPEAT_EN
  localparam int HR_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW     = $clog2(HR_MAX + 1);
  localparam logic [HW-1:0] HOLD_VAL   = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] REPEAT_VAL = HW'(REPEAT_TICKS);
`endif

  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync_btn;
  logic [PW-1:0]    presc;
  logic             tick;

  // Two-flop synchronizer bringing the raw levels into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_btn  <= '0;
    end else begin
      sync_meta <= i_btn;
      sync_btn  <= sync_meta;
    end
  end

  // Shared prescaler: wraps every TICK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (presc == TICK_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == TICK_LAST);

  // Registered copy of the sample tick for external observers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tick <= 1'b0;
    end else begin
      o_tick <= tick;
    end
  end

  generate
    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      logic [CW-1:0] flt_cnt;
      logic          state_q;
      logic          press_q;
      logic          rel_q;
      logic          differ;
      logic          accept;
      logic          rpt_fire;

      assign differ = (sync_btn[g] != state_q);
      // The tick on which the run of differing samples reaches STABLE_CNT
      assign accept = tick && differ && (flt_cnt == STABLE_LAST);

      // Debounce counter and accepted level
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flt_cnt <= '0;
          state_q <= 1'b0;
        end else if (tick) begin
          if (!differ) begin
            flt_cnt <= '0;
          end else if (accept) begin
            flt_cnt <= '0;
            state_q <= ~state_q;
          end else begin
            flt_cnt <= flt_cnt + CW'(1);
          end
        end
      end

`ifdef BUTTON_FILTER_REPEAT_EN
      logic [HW-1:0] hold_cnt;
      logic [HW-1:0] hold_next;
      logic          repeating;

      // Saturating increment; the counter is reloaded long before saturation
      assign hold_next = (hold_cnt == '1) ? hold_cnt : hold_cnt + HW'(1);
      // First repeat after HOLD_TICKS, later ones every REPEAT_TICKS
      assign rpt_fire  = tick && state_q && !accept &&
                         (repeating ? (hold_next == REPEAT_VAL) : (hold_next == HOLD_VAL));

      // Hold/repeat timer, cleared while released and on every accepted edge
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (!state_q || accept) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (tick) begin
          if (rpt_fire) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
          end else begin
            hold_cnt  <= hold_next;
          end
        end
      end
`else
      assign rpt_fire = 1'b0;
`endif

      // One-cycle event pulses following an accepted edge or a repeat
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          press_q <= 1'b0;
          rel_q   <= 1'b0;
        end else begin
          press_q <= (accept && !state_q) || rpt_fire;
          rel_q   <= accept && state_q;
        end
      end

      assign o_state[g]   = state_q;
      assign o_press[g]   = press_q;
      assign o_release[g] = rel_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_filter
// Description : Self-checking bench for button_filter: directed vector table,
//               hand-written multi-cycle sequences and randomized stimulus
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_filter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int S  = 3;
  localparam int H  = 8;
  localparam int R  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] st;
  logic [N-1:0] pr;
  logic [N-1:0] rl;
  logic         tk;

  button_filter #(
    .N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(S), .HOLD_TICKS(H), .REPEAT_TICKS(R)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(btn),
    .o_state(st), .o_press(pr), .o_release(rl), .o_tick(tk)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Filter sees the input sampled two edges earlier; a tick falls on every
  // TD-th edge since reset; a level is accepted after S consecutive
  // differing ticks; repeats fall H ticks after acceptance and every R after.
  int unsigned  m_edge = 0;
  int           m_run [N];
  int           m_held[N];
  logic [N-1:0] m_state = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;
  logic         m_tick  = 1'b0;
  logic [N-1:0] m_s     = '0;
  logic [N-1:0] m_hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge = 0; m_state = '0; m_press = '0; m_rel = '0; m_tick = 1'b0;
      m_hist.delete(); m_hist.push_back('0); m_hist.push_back('0);
      for (int c = 0; c < N; c++) begin m_run[c] = 0; m_held[c] = 0; end
    end else begin
      m_s = m_hist.pop_front();
      m_hist.push_back(btn);
      m_edge++;
      m_tick  = ((m_edge % TD) == 0);
      m_press = '0;
      m_rel   = '0;
      if (m_tick) begin
        for (int c = 0; c < N; c++) begin
          if (m_s[c] != m_state[c]) m_run[c]++;
          else m_run[c] = 0;
          if (m_run[c] == S) begin
            m_run[c] = 0;
            if (m_state[c]) m_rel[c] = 1'b1;
            else m_press[c] = 1'b1;
            m_state[c] = ~m_state[c];
            m_held[c]  = 0;
          end else if (m_state[c]) begin
            m_held[c]++;
`ifdef BUTTON_FILTER_REPEAT_EN
            if (m_held[c] == H || (m_held[c] > H && ((m_held[c] - H) % R) == 0))
              m_press[c] = 1'b1;
`endif
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model plus pulse-shape properties
  logic [N-1:0] prev_pulse = '0;
  always @(negedge clk) begin
    chk(st === m_state, "cyc_state",   int'(st), int'(m_state));
    chk(pr === m_press, "cyc_press",   int'(pr), int'(m_press));
    chk(rl === m_rel,   "cyc_release", int'(rl), int'(m_rel));
    chk(tk === m_tick,  "cyc_tick",    int'(tk), int'(m_tick));
    chk((pr & rl) === '0, "press_release_excl", int'(pr & rl), 0);
    chk(((pr | rl) & prev_pulse) === '0, "pulse_back_to_back", int'((pr | rl) & prev_pulse), 0);
    prev_pulse = pr | rl;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0] btn;
    int           cycles;
    logic [N-1:0] exp_state;
    int           exp_press_cycles;
    logic [N-1:0] exp_press_seen;
    int           exp_rel_cycles;
    logic [N-1:0] exp_rel_seen;
    string        name;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int           n;
    int           t;
    int           idx;
    int           rc;
    int           remain[N];
    logic [31:0]  at;
    logic [31:0]  expm;
    int           exp_rc;

    tbl[0] = '{4'b0010,  8, 4'b0000, 0, 4'b0000, 0, 4'b0000, "glitch_high"};
    tbl[1] = '{4'b0000, 16, 4'b0000, 0, 4'b0000, 0, 4'b0000, "glitch_low"};
    tbl[2] = '{4'b0001, 16, 4'b0001, 1, 4'b0001, 0, 4'b0000, "clean_press"};
    tbl[3] = '{4'b0000, 16, 4'b0000, 0, 4'b0000, 1, 4'b0001, "release"};
    tbl[4] = '{4'b1001, 16, 4'b1001, 1, 4'b1001, 0, 4'b0000, "simul_press"};
    tbl[5] = '{4'b0000, 16, 4'b0000, 0, 4'b0000, 1, 4'b1001, "simul_release"};
    tbl[6] = '{4'b0100,  4, 4'b0000, 0, 4'b0000, 0, 4'b0000, "short_glitch"};
    tbl[7] = '{4'b0000, 16, 4'b0000, 0, 4'b0000, 0, 4'b0000, "idle"};

    // reset state
    repeat (3) @(negedge clk);
    chk({st, pr, rl, tk} === '0, "reset_state", int'({st, pr, rl, tk}), 0);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      int           pc;
      int           rcy;
      logic [N-1:0] ps;
      logic [N-1:0] rs;
      pc = 0; rcy = 0; ps = '0; rs = '0;
      btn = tbl[i].btn;
      repeat (tbl[i].cycles) begin
        @(negedge clk);
        if (pr != '0) begin pc++;  ps |= pr; end
        if (rl != '0) begin rcy++; rs |= rl; end
      end
      chk(st === tbl[i].exp_state,        {tbl[i].name, "_state"},        int'(st), int'(tbl[i].exp_state));
      chk(pc == tbl[i].exp_press_cycles,  {tbl[i].name, "_press_cycles"}, pc,       tbl[i].exp_press_cycles);
      chk(ps === tbl[i].exp_press_seen,   {tbl[i].name, "_press_bits"},   int'(ps), int'(tbl[i].exp_press_seen));
      chk(rcy == tbl[i].exp_rel_cycles,   {tbl[i].name, "_rel_cycles"},   rcy,      tbl[i].exp_rel_cycles);
      chk(rs === tbl[i].exp_rel_seen,     {tbl[i].name, "_rel_bits"},     int'(rs), int'(tbl[i].exp_rel_seen));
      #1;
    end

    // ---- clean-press latency: 2 sync cycles + 2..3 tick periods ----
    btn = 4'b0001;
    n = 0;
    while (!st[0] && n < 40) begin @(negedge clk); n++; end
    chk(n >= 10 && n <= 14, "press_latency_cycles", n, 14);
    #1 btn = 4'b0000;
    n = 0;
    while (st[0] && n < 40) begin @(negedge clk); n++; end
    chk(st === '0, "latency_release_state", int'(st), 0);

    // ---- reset mid-filter with buttons held through reset ----
    #1 btn = 4'b1000;
    n = 0;
    while (!st[3] && n < 40) begin @(negedge clk); n++; end
    chk(st === 4'b1000, "pre_reset_state", int'(st), 32'h8);
    #1 btn = 4'b1001;
    n = 0; t = 0;
    while (t < 2 && n < 40) begin
      @(negedge clk); n++;
      if (tk && n >= 3) t++;
    end
    chk(t == 2, "two_differing_ticks", t, 2);
    #1 rst = 1'b1;
    #1;
    chk({st, pr, rl, tk} === '0, "reset_async_clear", int'({st, pr, rl, tk}), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (st[0] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk(n == 12, "reaccept_after_reset_cycles", n, 12);
    chk(pr === 4'b1001, "reaccept_press", int'(pr), 32'h9);
    #1 btn = 4'b0000;
    n = 0;
    while (st !== '0 && n < 60) begin @(negedge clk); n++; end
    chk(st === '0, "post_reset_release", int'(st), 0);

    // ---- long hold: auto-repeat when compiled in, single pulse otherwise ----
    repeat (8) @(negedge clk);
    #1 btn = 4'b0001;
    n = 0;
    while (pr[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk(pr[0] === 1'b1, "hold_initial_press", int'(pr[0]), 1);
    idx = 0; rc = 0; at = '0; n = 0;
    while (idx < 20 && n < 200) begin
      @(negedge clk); n++;
      if (tk) idx++;
      if (pr[0]) begin rc++; at[idx] = 1'b1; end
    end
`ifdef BUTTON_FILTER_REPEAT_EN
    exp_rc = 7;
    expm   = '0;
    for (int k = 8; k <= 20; k += 2) expm[k] = 1'b1;
`else
    exp_rc = 0;
    expm   = '0;
`endif
    chk(rc == exp_rc, "repeat_count", rc, exp_rc);
    chk(at === expm, "repeat_tick_positions", int'(at), int'(expm));
    #1 btn = 4'b0000;
    n = 0;
    while (rl[0] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk(rl[0] === 1'b1, "hold_release_pulse", int'(rl[0]), 1);
    rc = 0;
    repeat (40) begin @(negedge clk); if (pr[0]) rc++; end
    chk(rc == 0, "no_repeat_after_release", rc, 0);
    chk(st === '0, "hold_final_state", int'(st), 0);

    // ---- randomized stimulus, checked every cycle against the model ----
    for (int c = 0; c < N; c++) remain[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc == 2000) rst = 1'b1;
      if (cyc == 2002) rst = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (remain[c] == 0) begin
          btn[c]    = 1'($urandom_range(0, 1));
          remain[c] = int'($urandom_range(1, 60));
        end else begin
          remain[c]--;
        end
      end
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
